// File: rtl/score_bcd_converter.sv
`timescale 1ns/1ps
// score_bcd_converter
//   Sequential binary-to-BCD converter for the game score. On each rising edge
//   of frame_clk (VGA_VS) the current Score is converted with a shift-add-3
//   (double-dabble) FSM, one bit per Clk cycle, and the decimal digits are
//   presented to the HexDriver instances. Also tracks the session high score.
//
//   Ports
//     Clk        system clock (MAX10_CLK1_50)
//     Reset_n    synchronous reset, active-low
//     frame_clk  conversion request (VGA_VS), unsynchronised
//     Score      binary score from jumplogic
//     clear_hi   level; clears the high score
//     bcd        current score digits, digit i = bcd[4i+3:4i], i=0 is ones
//     hi_bcd     high score digits, same packing
//     digit_en   leading-zero mask for bcd (bit0 always set)
//     bcd_valid  one-cycle pulse when bcd/digit_en/overflow update
//     busy       high while a conversion is in progress (LOAD/SHIFT/DONE)
//     overflow   last converted Score did not fit in DIGITS decimal digits
module score_bcd_converter #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic [BIN_W-1:0]      Score,
    input  logic                  clear_hi,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [4*DIGITS-1:0]   hi_bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state;
    logic               fsync1, fsync2, fhist;
    logic               req;
    logic               pending;
    logic [BIN_W-1:0]   sh_bin;
    logic [BIN_W-1:0]   lat_bin;
    logic [BIN_W-1:0]   hi_bin;
    logic [BCD_W-1:0]   sh_bcd;
    logic [BCD_W-1:0]   adj_bcd;
    logic [BCD_W-1:0]   nxt_bcd;
    logic [BIN_W-1:0]   nxt_bin;
    logic               ovf_acc;
    logic               nxt_ovf;
    logic [CNT_W-1:0]   cnt;
    logic [DIGITS-1:0]  nxt_en;
    logic               nz_acc;

    assign req = fsync2 & ~fhist;

    // One double-dabble step: correct every nibble >= 5, then shift left.
    // The bit leaving the top nibble is a carry of 10**DIGITS.
    always_comb begin
        adj_bcd = sh_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sh_bcd[4*i +: 4] >= 4'd5)
                adj_bcd[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
        end
        nxt_bcd = {adj_bcd[BCD_W-2:0], sh_bin[BIN_W-1]};
        nxt_bin = {sh_bin[BIN_W-2:0], 1'b0};
        nxt_ovf = ovf_acc | adj_bcd[BCD_W-1];
    end

    // Leading-zero mask: sweep from the most significant digit downwards.
    always_comb begin
        nxt_en = '0;
        nz_acc = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nz_acc = nz_acc | (nxt_bcd[4*(DIGITS-1-k) +: 4] != 4'd0);
            nxt_en[DIGITS-1-k] = nz_acc;
        end
        nxt_en[0] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            fsync1      <= 1'b0;
            fsync2      <= 1'b0;
            fhist       <= 1'b0;
            pending     <= 1'b0;
            sh_bin      <= '0;
            lat_bin     <= '0;
            hi_bin      <= '0;
            sh_bcd      <= '0;
            ovf_acc     <= 1'b0;
            cnt         <= '0;
            bcd         <= '0;
            hi_bcd      <= '0;
            digit_en    <= '0;
            digit_en[0] <= 1'b1;
            bcd_valid   <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            fsync1    <= frame_clk;
            fsync2    <= fsync1;
            fhist     <= fsync2;
            bcd_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req || pending) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    sh_bin  <= Score;
                    lat_bin <= Score;
                    sh_bcd  <= '0;
                    cnt     <= '0;
                    ovf_acc <= 1'b0;
                    // A request arriving in this very cycle must survive the clear.
                    pending <= req;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (req)
                        pending <= 1'b1;
                    sh_bcd  <= nxt_bcd;
                    sh_bin  <= nxt_bin;
                    ovf_acc <= nxt_ovf;
                    cnt     <= cnt + CNT_W'(1);
                    // Outputs are loaded from the final step so that they are
                    // already valid while the FSM sits in DONE.
                    if (cnt == LAST_CNT) begin
                        bcd       <= nxt_bcd;
                        overflow  <= nxt_ovf;
                        digit_en  <= nxt_en;
                        bcd_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (req)
                        pending <= 1'b1;
                    if (!overflow && (lat_bin > hi_bin)) begin
                        hi_bin <= lat_bin;
                        hi_bcd <= sh_bcd;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            if (clear_hi) begin
                hi_bin <= '0;
                hi_bcd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
`timescale 1ns/1ps
module tb_score_bcd_converter;

    logic        MAX10_CLK1_50 = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        frame_clk = 1'b0;
    logic [11:0] Score     = '0;
    logic        clear_hi  = 1'b0;
    logic [15:0] bcd, hi_bcd;
    logic [3:0]  digit_en;
    logic        bcd_valid, busy, overflow;

    logic        frame_clk3 = 1'b0;
    logic [11:0] score3     = '0;
    logic [11:0] bcd3, hi_bcd3;
    logic [2:0]  digit_en3;
    logic        bcd_valid3, busy3, overflow3;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  en;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   assertions  = 0;
    int   failures    = 0;
    int   hi_model    = 0;
    int   valid_count = 0;

    always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    score_bcd_converter #(.BIN_W(12), .DIGITS(4)) dut (
        .Clk(MAX10_CLK1_50), .Reset_n(Reset_n), .frame_clk(frame_clk), .Score(Score),
        .clear_hi(clear_hi), .bcd(bcd), .hi_bcd(hi_bcd), .digit_en(digit_en),
        .bcd_valid(bcd_valid), .busy(busy), .overflow(overflow)
    );

    score_bcd_converter #(.BIN_W(12), .DIGITS(3)) dut3 (
        .Clk(MAX10_CLK1_50), .Reset_n(Reset_n), .frame_clk(frame_clk3), .Score(score3),
        .clear_hi(clear_hi), .bcd(bcd3), .hi_bcd(hi_bcd3), .digit_en(digit_en3),
        .bcd_valid(bcd_valid3), .busy(busy3), .overflow(overflow3)
    );

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_en(input int v);
        logic [3:0] r;
        r[0] = 1'b1;
        r[1] = (v >= 10);
        r[2] = (v >= 100);
        r[3] = (v >= 1000);
        return r;
    endfunction

    task automatic push_exp(input int v);
        exp_t e;
        e.bcd = model_bcd(v);
        e.en  = model_en(v);
        e.ovf = 1'b0;
        sb.push_back(e);
        if (v > hi_model) hi_model = v;
    endtask

    // Scoreboard checker: every bcd_valid pulse consumes one expected result.
    always @(negedge MAX10_CLK1_50) begin
        if (Reset_n && bcd_valid) begin
            valid_count++;
            assertions++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got bcd=%h en=%b ovf=%b, required no pulse", bcd, digit_en, overflow);
            end else begin
                mon_e = sb.pop_front();
                if ({bcd, digit_en, overflow} !== {mon_e.bcd, mon_e.en, mon_e.ovf}) begin
                    failures++;
                    $display("FAIL sb_result: got bcd=%h en=%b ovf=%b, required bcd=%h en=%b ovf=%b",
                             bcd, digit_en, overflow, mon_e.bcd, mon_e.en, mon_e.ovf);
                end
            end
        end
    end

    // Drive one conversion request and wait (bounded) for bcd_valid.
    // lat = number of posedges from the frame_clk rise to the pulse, 0 on timeout.
    task automatic convert(input int v, input bit clr_done, output int lat);
        bit got;
        got = 0;
        lat = 0;
        Score = 12'(v);
        push_exp(v);
        @(negedge MAX10_CLK1_50);
        frame_clk = 1'b1;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge MAX10_CLK1_50); #1;
            if (n == 3) frame_clk = 1'b0;
            if (bcd_valid) begin
                got = 1;
                lat = n;
            end
        end
        frame_clk = 1'b0;
        if (!got) begin
            assertions++;
            failures++;
            $display("FAIL convert_timeout: got no bcd_valid in 40 cycles, required one for Score=%0d", v);
        end
        if (clr_done) clear_hi = 1'b1;
        @(posedge MAX10_CLK1_50); #1;
        if (clr_done) begin
            clear_hi = 1'b0;
            hi_model = 0;
        end
        @(posedge MAX10_CLK1_50); #1;
    endtask

    task automatic convert3(input int v, output bit got);
        got = 0;
        score3 = 12'(v);
        @(negedge MAX10_CLK1_50);
        frame_clk3 = 1'b1;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge MAX10_CLK1_50); #1;
            if (n == 3) frame_clk3 = 1'b0;
            if (bcd_valid3) got = 1;
        end
        frame_clk3 = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge MAX10_CLK1_50);
        #1;
        assertions++;
        if ({bcd, hi_bcd, digit_en, bcd_valid, busy, overflow} !== {16'h0, 16'h0, 4'b0001, 3'b000}) begin
            failures++;
            $display("FAIL reset_main: got bcd=%h hi=%h en=%b v=%b b=%b o=%b, required 0000 0000 0001 0 0 0",
                     bcd, hi_bcd, digit_en, bcd_valid, busy, overflow);
        end
        assertions++;
        if ({bcd3, hi_bcd3, digit_en3, bcd_valid3, busy3, overflow3} !== {12'h0, 12'h0, 3'b001, 3'b000}) begin
            failures++;
            $display("FAIL reset_d3: got bcd=%h hi=%h en=%b v=%b b=%b o=%b, required 000 000 001 0 0 0",
                     bcd3, hi_bcd3, digit_en3, bcd_valid3, busy3, overflow3);
        end
        Reset_n = 1'b1;
        @(posedge MAX10_CLK1_50); #1;
    endtask

    task automatic test_latency();
        int lat;
        int seen_busy;
        seen_busy = 0;
        convert(4095, 0, lat);
        assertions++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL latency: got %0d cycles from frame_clk rise, required 16 (14 after req)", lat);
        end
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_idle: got %b, required 0", busy);
        end
        assertions++;
        if (hi_bcd !== model_bcd(hi_model)) begin
            failures++;
            $display("FAIL hi_4095: got %h, required %h", hi_bcd, model_bcd(hi_model));
        end
        // busy must be visible mid-conversion
        Score = 12'd7;
        push_exp(7);
        @(negedge MAX10_CLK1_50);
        frame_clk = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge MAX10_CLK1_50); #1;
            if (n == 3) frame_clk = 1'b0;
            if (n == 8 && busy) seen_busy = 1;
        end
        assertions++;
        if (seen_busy !== 1) begin
            failures++;
            $display("FAIL busy_mid: got busy=0 during SHIFT, required 1");
        end
    endtask

    task automatic test_small_values();
        int lat;
        convert(0, 0, lat);
        convert(99, 0, lat);
        assertions++;
        if (hi_bcd !== 16'h4095) begin
            failures++;
            $display("FAIL hi_kept: got %h, required 4095", hi_bcd);
        end
    endtask

    task automatic test_high_score();
        int lat;
        clear_hi = 1'b1;
        @(posedge MAX10_CLK1_50); #1;
        clear_hi = 1'b0;
        hi_model = 0;
        assertions++;
        if (hi_bcd !== 16'h0000) begin
            failures++;
            $display("FAIL hi_clear: got %h, required 0000", hi_bcd);
        end
        convert(1000, 0, lat);
        convert(250, 0, lat);
        assertions++;
        if (hi_bcd !== model_bcd(hi_model)) begin
            failures++;
            $display("FAIL hi_1000: got %h, required %h", hi_bcd, model_bcd(hi_model));
        end
        convert(1000, 0, lat);
        assertions++;
        if (hi_bcd !== 16'h1000) begin
            failures++;
            $display("FAIL hi_equal: got %h, required 1000", hi_bcd);
        end
        convert(1234, 0, lat);
        assertions++;
        if (hi_bcd !== model_bcd(hi_model)) begin
            failures++;
            $display("FAIL hi_1234: got %h, required %h", hi_bcd, model_bcd(hi_model));
        end
        convert(2000, 1, lat);
        assertions++;
        if (hi_bcd !== 16'h0000) begin
            failures++;
            $display("FAIL hi_clear_wins: got %h, required 0000", hi_bcd);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        Score = 12'd10;
        push_exp(10);
        @(negedge MAX10_CLK1_50);
        frame_clk = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge MAX10_CLK1_50); #1;
            if (n == 3) frame_clk = 1'b0;
            if (n == 6) begin
                frame_clk = 1'b1;
                Score = 12'd37;
                push_exp(37);
            end
            if (n == 9) frame_clk = 1'b0;
            if (bcd_valid) pulses++;
        end
        assertions++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d, required 2", pulses);
        end
        assertions++;
        if (bcd !== 16'h0037) begin
            failures++;
            $display("FAIL b2b_final: got %h, required 0037", bcd);
        end
        assertions++;
        if (hi_bcd !== model_bcd(hi_model)) begin
            failures++;
            $display("FAIL b2b_hi: got %h, required %h", hi_bcd, model_bcd(hi_model));
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int lat;
        pulses = 0;
        Score = 12'd321;
        @(negedge MAX10_CLK1_50);
        frame_clk = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge MAX10_CLK1_50); #1;
            if (n == 3) frame_clk = 1'b0;
        end
        // now in the 5th SHIFT cycle
        Reset_n = 1'b0;
        @(posedge MAX10_CLK1_50); #1;
        Reset_n = 1'b1;
        hi_model = 0;
        assertions++;
        if ({bcd, hi_bcd, digit_en, bcd_valid, busy, overflow} !== {16'h0, 16'h0, 4'b0001, 3'b000}) begin
            failures++;
            $display("FAIL midreset_state: got bcd=%h hi=%h en=%b v=%b b=%b o=%b, required 0000 0000 0001 0 0 0",
                     bcd, hi_bcd, digit_en, bcd_valid, busy, overflow);
        end
        for (int n = 0; n < 30; n++) begin
            @(posedge MAX10_CLK1_50); #1;
            if (bcd_valid) pulses++;
        end
        assertions++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL midreset_novalid: got %0d pulses, required 0", pulses);
        end
        convert(321, 0, lat);
        assertions++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL midreset_latency: got %0d, required 16", lat);
        end
        assertions++;
        if (hi_bcd !== 16'h0321) begin
            failures++;
            $display("FAIL midreset_hi: got %h, required 0321", hi_bcd);
        end
    endtask

    task automatic test_digits3();
        bit got;
        logic [15:0] full;
        logic [3:0]  en4;
        logic [11:0] exp_bcd;
        logic [2:0]  exp_en;
        convert3(500, got);
        full = model_bcd(500);
        en4 = model_en(500);
        exp_bcd = full[11:0];
        exp_en = en4[2:0];
        assertions++;
        if (!got || {bcd3, digit_en3, overflow3} !== {exp_bcd, exp_en, 1'b0}) begin
            failures++;
            $display("FAIL d3_500: got valid=%b bcd=%h en=%b ovf=%b, required bcd=%h en=%b ovf=0",
                     got, bcd3, digit_en3, overflow3, exp_bcd, exp_en);
        end
        repeat (2) @(posedge MAX10_CLK1_50);
        #1;
        assertions++;
        if (hi_bcd3 !== 12'h500) begin
            failures++;
            $display("FAIL d3_hi500: got %h, required 500", hi_bcd3);
        end
        convert3(1234, got);
        full = model_bcd(1234);
        en4 = model_en(1234 % 1000);
        exp_bcd = full[11:0];
        exp_en = en4[2:0];
        assertions++;
        if (!got || {bcd3, digit_en3, overflow3} !== {exp_bcd, exp_en, 1'b1}) begin
            failures++;
            $display("FAIL d3_1234: got valid=%b bcd=%h en=%b ovf=%b, required bcd=%h en=%b ovf=1",
                     got, bcd3, digit_en3, overflow3, exp_bcd, exp_en);
        end
        repeat (2) @(posedge MAX10_CLK1_50);
        #1;
        assertions++;
        if (hi_bcd3 !== 12'h500) begin
            failures++;
            $display("FAIL d3_hi_kept: got %h, required 500", hi_bcd3);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_small_values();
        test_high_score();
        test_back_to_back();
        test_reset_mid();
        test_digits3();
        repeat (3) @(posedge MAX10_CLK1_50);
        #1;
        assertions++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d outstanding results, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
